// File: rtl/rom_arbiter_if.sv
// Bundle of requester handshake and ROM pins shared by the arbiter and its users.
// The slave side is the arbiter; the master side is the requesters plus the ROM.
interface rom_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 8,
  parameter int WIDTH   = 8
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ-1:0]    ack;
  logic [NUM_REQ-1:0]    rd_valid;
  logic [WIDTH-1:0]      rd_data;
  logic [AW-1:0]         rom_addr;
  logic [WIDTH-1:0]      rom_data;

  modport slave (
    input  req, req_addr, rom_data,
    output ack, rd_valid, rd_data, rom_addr
  );

  modport master (
    output req, req_addr, rom_data,
    input  ack, rd_valid, rd_data, rom_addr
  );
endinterface

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM among NUM_REQ requesters.
// Grant, ROM read and data return form a fixed 3-cycle pipeline, one grant per clock.
module rom_arbiter #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 256,
  parameter int NUM_REQ = 4
) (
  input logic          clock,
  input logic          reset_n,
  rom_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] rdValid_q, rdValid_d;
  logic [WIDTH-1:0]   rdData_q, rdData_d;
  logic [AW-1:0]      romAddr_q, romAddr_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      tag1_q, tag1_d;
  logic [IW-1:0]      tag2_q;
  logic               valid1_q, valid1_d;
  logic               valid2_q;

  logic [NUM_REQ-1:0] eligible;
  logic [IW-1:0]      winner;
  logic [IW-1:0]      scanIdx;
  logic [AW-1:0]      winnerAddr;
  logic               grant;

  // A requester is masked in its own ack cycle so a held req is never granted twice.
  always_comb begin
    eligible = bus.req & ~ack_q;
    grant    = 1'b0;
    winner   = '0;
    scanIdx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scanIdx = (int'(ptr_q) + k >= NUM_REQ) ? IW'(int'(ptr_q) + k - NUM_REQ)
                                             : IW'(int'(ptr_q) + k);
      if (!grant && eligible[scanIdx]) begin
        grant  = 1'b1;
        winner = scanIdx;
      end
    end
  end

  always_comb begin
    winnerAddr = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (winner == IW'(j)) begin
        winnerAddr = bus.req_addr[j*AW +: AW];
      end
    end
  end

  always_comb begin
    ack_d     = '0;
    valid1_d  = grant;
    tag1_d    = winner;
    romAddr_d = romAddr_q;
    ptr_d     = ptr_q;
    if (grant) begin
      ack_d[winner] = 1'b1;
      romAddr_d     = winnerAddr;
      ptr_d         = (winner == LAST) ? '0 : winner + 1'b1;
    end
  end

  // Stage 2 lines up with the ROM's registered output, so its data is captured here.
  always_comb begin
    rdValid_d = '0;
    rdData_d  = rdData_q;
    if (valid2_q) begin
      rdValid_d[tag2_q] = 1'b1;
      rdData_d          = bus.rom_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ack_q     <= '0;
      rdValid_q <= '0;
      rdData_q  <= '0;
      romAddr_q <= '0;
      ptr_q     <= '0;
      tag1_q    <= '0;
      tag2_q    <= '0;
      valid1_q  <= 1'b0;
      valid2_q  <= 1'b0;
    end else begin
      ack_q     <= ack_d;
      rdValid_q <= rdValid_d;
      rdData_q  <= rdData_d;
      romAddr_q <= romAddr_d;
      ptr_q     <= ptr_d;
      tag1_q    <= tag1_d;
      tag2_q    <= tag1_q;
      valid1_q  <= valid1_d;
      valid2_q  <= valid1_q;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.rd_valid = rdValid_q;
  assign bus.rd_data  = rdData_q;
  assign bus.rom_addr = romAddr_q;
endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter with a ROM holding memory[a] = ~a and four requesters.
// A queue-based reference model predicts ack, rom_addr and the tagged read data.
module tb_rom_arbiter;
  localparam int NR = 4;
  localparam int AW = 8;
  localparam int W  = 8;

  typedef struct {
    int          due;
    int          who;
    logic [W-1:0] data;
  } resp_t;

  logic clock = 1'b0;
  logic resetN;

  rom_arbiter_if #(.NUM_REQ(NR), .AW(AW), .WIDTH(W)) bus ();

  rom_arbiter #(.WIDTH(W), .DEPTH(256), .NUM_REQ(NR)) dut (
    .clock   (clock),
    .reset_n (resetN),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Behavioural synchronous ROM: one-cycle registered read of ~address.
  always @(posedge clock) begin
    bus.rom_data <= ~bus.rom_addr;
  end

  int checks = 0;
  int errors = 0;

  logic [NR-1:0] reqV;
  logic [AW-1:0] addrV [NR];

  int            mP;
  int            cyc;
  logic [NR-1:0] mAck;
  logic [NR-1:0] mRdValid;
  logic [W-1:0]  mRdData;
  logic [AW-1:0] mRomAddr;
  resp_t         pend [$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic modelReset();
    mP       = 0;
    mAck     = '0;
    mRdValid = '0;
    mRdData  = '0;
    mRomAddr = '0;
    pend.delete();
  endtask

  // Reference: round-robin scan from the pointer, reads return ~addr two edges after the grant edge.
  task automatic runModel();
    logic [NR-1:0] elig;
    int            win;
    resp_t         r;
    cyc++;
    elig = reqV & ~mAck;
    win  = -1;
    for (int k = 0; k < NR; k++) begin
      if (win < 0 && elig[(mP + k) % NR]) win = (mP + k) % NR;
    end
    mRdValid = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      mRdValid[pend[0].who] = 1'b1;
      mRdData = pend[0].data;
      void'(pend.pop_front());
    end
    mAck = '0;
    if (win >= 0) begin
      mAck[win] = 1'b1;
      mRomAddr  = addrV[win];
      mP        = (win + 1) % NR;
      r.due     = cyc + 2;
      r.who     = win;
      r.data    = ~addrV[win];
      pend.push_back(r);
    end
  endtask

  task automatic driveInputs();
    bus.req = reqV;
    for (int i = 0; i < NR; i++) bus.req_addr[i*AW +: AW] = addrV[i];
  endtask

  task automatic compareAll();
    checkOutput("ack", 32'(bus.ack), 32'(mAck));
    checkOutput("rd_valid", 32'(bus.rd_valid), 32'(mRdValid));
    checkOutput("rd_data", 32'(bus.rd_data), 32'(mRdData));
    checkOutput("rom_addr", 32'(bus.rom_addr), 32'(mRomAddr));
  endtask

  task automatic stepClock();
    driveInputs();
    @(posedge clock);
    if (resetN) runModel();
    #1;
    compareAll();
  endtask

  task automatic applyStimulus(input logic [NR-1:0] r);
    reqV = r;
    stepClock();
  endtask

  task automatic dropOnAck();
    reqV = reqV & ~mAck;
  endtask

  initial begin
    int            ackCount;
    int            rdCount;
    logic [AW-1:0] a;
    logic [W-1:0]  want;

    cyc    = 0;
    resetN = 1'b0;
    modelReset();
    reqV = NR'($urandom);
    for (int i = 0; i < NR; i++) addrV[i] = AW'($urandom);
    bus.rom_data = '0;

    $display("[TB] reset with random requests");
    for (int c = 0; c < 3; c++) begin
      applyStimulus(NR'($urandom));
      checkOutput("reset_ack", 32'(bus.ack), 32'd0);
      checkOutput("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
      checkOutput("reset_rd_data", 32'(bus.rd_data), 32'd0);
      checkOutput("reset_rom_addr", 32'(bus.rom_addr), 32'd0);
    end
    resetN = 1'b1;
    for (int c = 0; c < 3; c++) begin
      applyStimulus('0);
      checkOutput("idle_ack", 32'(bus.ack), 32'd0);
      checkOutput("idle_rd_valid", 32'(bus.rd_valid), 32'd0);
    end

    $display("[TB] single read");
    addrV[2] = 8'h10;
    applyStimulus(4'b0100);
    checkOutput("single_ack", 32'(bus.ack), 32'h4);
    checkOutput("single_rom_addr", 32'(bus.rom_addr), 32'h10);
    dropOnAck();
    stepClock();
    checkOutput("single_ack_once", 32'(bus.ack), 32'h0);
    stepClock();
    checkOutput("single_rd_valid", 32'(bus.rd_valid), 32'h4);
    checkOutput("single_rd_data", 32'(bus.rd_data), 32'hEF);
    stepClock();
    checkOutput("single_rd_once", 32'(bus.rd_valid), 32'h0);

    // Grant requester 3 once so the pointer wraps back to 0.
    addrV[3] = 8'h33;
    applyStimulus(4'b1000);
    dropOnAck();
    for (int c = 0; c < 3; c++) stepClock();

    $display("[TB] simultaneous requests");
    for (int i = 0; i < NR; i++) addrV[i] = AW'(i + 1);
    reqV = 4'b1111;
    for (int c = 1; c <= 6; c++) begin
      stepClock();
      if (c <= 4) checkOutput("simul_ack", 32'(bus.ack), 32'(1 << (c - 1)));
      if (c >= 3) begin
        a    = AW'(c - 2);
        want = ~a;
        checkOutput("simul_rd_valid", 32'(bus.rd_valid), 32'(1 << (c - 3)));
        checkOutput("simul_rd_data", 32'(bus.rd_data), 32'(want));
      end
      dropOnAck();
    end

    // Grant requester 0 alone so the pointer sits at 1.
    addrV[0] = 8'h05;
    applyStimulus(4'b0001);
    dropOnAck();
    for (int c = 0; c < 3; c++) stepClock();

    $display("[TB] fairness between requesters 0 and 3");
    addrV[0] = 8'h20;
    addrV[3] = 8'h30;
    reqV = 4'b1001;
    for (int c = 1; c <= 8; c++) begin
      stepClock();
      checkOutput("fair_ack", 32'(bus.ack), (c % 2 == 1) ? 32'h8 : 32'h1);
    end
    reqV = '0;
    for (int c = 0; c < 4; c++) stepClock();

    $display("[TB] single hog");
    addrV[1] = 8'h40;
    reqV     = 4'b0010;
    ackCount = 0;
    rdCount  = 0;
    for (int c = 1; c <= 9; c++) begin
      if (c == 7) reqV = '0;
      stepClock();
      if (c <= 6) checkOutput("hog_ack", 32'(bus.ack), (c % 2 == 1) ? 32'h2 : 32'h0);
      if (bus.ack[1]) ackCount++;
      if (bus.rd_valid[1]) begin
        a    = AW'(8'h40 + rdCount);
        want = ~a;
        checkOutput("hog_rd_data", 32'(bus.rd_data), 32'(want));
        rdCount++;
      end
      if (mAck[1]) addrV[1] = addrV[1] + 1'b1;
    end
    checkOutput("hog_ack_count", 32'(ackCount), 32'd3);
    checkOutput("hog_rd_count", 32'(rdCount), 32'd3);

    $display("[TB] reset mid-flight");
    addrV[0] = 8'h50;
    addrV[1] = 8'h51;
    applyStimulus(4'b0011);
    dropOnAck();
    stepClock();
    dropOnAck();
    stepClock();
    resetN = 1'b0;
    modelReset();
    #1;
    checkOutput("midrst_ack", 32'(bus.ack), 32'd0);
    checkOutput("midrst_rd_valid", 32'(bus.rd_valid), 32'd0);
    checkOutput("midrst_rd_data", 32'(bus.rd_data), 32'd0);
    checkOutput("midrst_rom_addr", 32'(bus.rom_addr), 32'd0);
    stepClock();
    stepClock();
    resetN = 1'b1;
    for (int c = 0; c < 4; c++) begin
      applyStimulus('0);
      checkOutput("post_rst_no_rd", 32'(bus.rd_valid), 32'd0);
    end
    addrV[1] = 8'h66;
    addrV[3] = 8'h77;
    applyStimulus(4'b1010);
    checkOutput("post_rst_ptr0", 32'(bus.ack), 32'h2);
    dropOnAck();
    stepClock();
    checkOutput("post_rst_ack3", 32'(bus.ack), 32'h8);
    dropOnAck();
    stepClock();
    checkOutput("post_rst_rd_valid1", 32'(bus.rd_valid), 32'h2);
    checkOutput("post_rst_rd_data1", 32'(bus.rd_data), 32'h99);
    stepClock();
    checkOutput("post_rst_rd_valid3", 32'(bus.rd_valid), 32'h8);
    checkOutput("post_rst_rd_data3", 32'(bus.rd_data), 32'h88);

    $display("[TB] randomized traffic");
    reqV = '0;
    for (int c = 0; c < 400; c++) begin
      stepClock();
      for (int i = 0; i < NR; i++) begin
        if (reqV[i] && mAck[i]) begin
          if ($urandom_range(1, 0) == 0) reqV[i] = 1'b0;
          else addrV[i] = AW'($urandom);
        end else if (reqV[i]) begin
          if ($urandom_range(15, 0) == 0) reqV[i] = 1'b0;
        end else if ($urandom_range(2, 0) == 0) begin
          reqV[i]  = 1'b1;
          addrV[i] = AW'($urandom);
        end
      end
    end
    reqV = '0;
    for (int c = 0; c < 5; c++) stepClock();
    checkOutput("drain_pending", 32'(pend.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Round-robin arbiter that shares a single synchronous ROM (one-cycle registered read) among NUM_REQ requesters, e.g. several sprite/star renderers reading one shared pattern table. It sits between the requesters and the ROM's addr/data pins. It accepts up to one read per clock, tags each read with its requester, and returns the data on a shared bus with a one-hot valid. It is fully pipelined: the fixed latency from request to data is 3 cycles.

## Interface
- WIDTH, 8: ROM data width in bits.
- DEPTH, 256: ROM depth in words. AW = $clog2(DEPTH).
- NUM_REQ, 4: number of requesters, 2..8.

- clock  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  req[i] high = requester i wants a read.
- req_addr  in  NUM_REQ*AW  packed addresses; requester i uses [i*AW +: AW].
- ack  out  NUM_REQ  one-hot, one-cycle pulse: the request of i was accepted.
- rd_valid  out  NUM_REQ  one-hot, one-cycle pulse: rd_data belongs to requester i.
- rd_data  out  WIDTH  returned ROM word.
- rom_addr  out  AW  address to the ROM; registered.
- rom_data  in  WIDTH  ROM output; valid one cycle after rom_addr.

## Operation
- Requester contract:
  - Hold req[i] and its address stable until ack[i] is seen.
  - In the ack cycle, the requester may drop req or present a new address for a further read.
- Eligibility: in cycle T, requester i is eligible when req[i]=1 and ack[i]=0. The arbiter masks a requester in its own ack cycle, so a held req is never double-granted.
- Round-robin pointer p (range 0..NUM_REQ-1, reset 0):
  - The winner w is the first eligible index scanning p, p+1, … modulo NUM_REQ.
- On a grant, at the edge ending T:
  - rom_addr <= address of w.
  - ack <= onehot(w).
  - p <= (w+1) mod NUM_REQ.
  - Stage-1 tag <= w, stage-1 valid <= 1.
- No eligible requester:
  - ack <= 0 and stage-1 valid <= 0.
  - rom_addr and p hold their values.
- Pipeline:
  - Stage-1 (tag, valid) moves to stage-2 at the next edge, in step with the ROM's internal read.
  - On stage-2 valid: rd_data <= rom_data and rd_valid <= onehot(tag2).
  - Otherwise rd_valid <= 0 and rd_data holds.
- Throughput:
  - Aggregate: one grant per cycle.
  - A single requester holding req continuously: one grant every 2 cycles.
  - Two or more requesters: the grant alternates every cycle (see timing).
- Ordering: responses return in grant order, with exactly one rd_valid per ack.
- Reset, asynchronous assert:
  - ack=0, rd_valid=0, rd_data=0, rom_addr=0, p=0, both stage valids=0.
  - In-flight reads are discarded, so no rd_valid for them after reset releases.
- req dropped without ack: legal. Nothing is issued for it.

## Timing
- T: req[i]=1 with addr A sampled, and i wins.
- T+1: ack[i]=1 and rom_addr=A. The ROM registers memory[A] at the edge ending T+1.
- T+2: rom_data=memory[A]. The arbiter captures it at the edge ending T+2.
- T+3: rd_valid[i]=1 and rd_data=memory[A]. Latency from the req-sampling edge is 3 cycles.
- Back-to-back example, requesters 0 and 1 both held high, p=0:
  - acks occur in the order 0,1,0,1 on consecutive cycles.
  - rd_valid follows 3 cycles later in the same order.
- All outputs are registered, with no combinational path from req to ack.

## Test plan
The bench instantiates rom_sync with DEPTH=256, WIDTH=8 and contents memory[a] = ~a; NUM_REQ=4.

- Reset: hold reset_n=0 with random req. Require ack=0, rd_valid=0, rd_data=0, rom_addr=0. After release with req=0, all outputs stay 0.
- Single read: req[2]=1 with addr 8'h10 in cycle 0, dropped after ack. Require:
  - ack=4'b0100 in cycle 1 only;
  - rom_addr=8'h10 in cycle 1;
  - rd_valid=4'b0100 with rd_data=8'hEF in cycle 3 only.
- Simultaneous requests, p=0: req=4'b1111 with addrs 1,2,3,4, each dropping after its ack. Require:
  - acks 0,1,2,3 in cycles 1-4;
  - rd_data FE,FD,FC,FB in cycles 3-6 with the matching rd_valid.
- Fairness: req[0] and req[3] held high for 8 cycles starting with p=1. Require acks to alternate 3,0,3,0,…, with no requester skipped and no cycle without an ack.
- Single hog: only req[1] held for 6 cycles, addr incrementing after each ack. Require ack[1] on every other cycle, 3 acks in total, and 3 rd_valid pulses with the correct data.
- Reset mid-flight: assert reset_n=0 one cycle after two acks are issued. Require no rd_valid after release, and the next request served with the 3-cycle latency starting from p=0.
